// File: rtl/ram_dp_sync.sv
// Single-clock true dual-port RAM with byte enables, registered reads and collision counting.
// Optional per-lane even parity is enabled with `define RAM_DP_SYNC_PARITY_EN.
module ram_dp_sync #(
    parameter int ADDR_MSB   = 6,
    parameter int MEM_SIZE   = 256,
    parameter int DATA_WIDTH = 16,
    parameter int RDW_MODE   = 0
) (
    input  logic                      mclk,
    input  logic                      puc_rst,
    input  logic [ADDR_MSB:0]         ram_addra,
    input  logic                      ram_cena,
    input  logic [DATA_WIDTH/8-1:0]   ram_wena,
    input  logic [DATA_WIDTH-1:0]     ram_dina,
    output logic [DATA_WIDTH-1:0]     ram_douta,
    input  logic [ADDR_MSB:0]         ram_addrb,
    input  logic                      ram_cenb,
    input  logic [DATA_WIDTH/8-1:0]   ram_wenb,
    input  logic [DATA_WIDTH-1:0]     ram_dinb,
    output logic [DATA_WIDTH-1:0]     ram_doutb,
`ifdef RAM_DP_SYNC_PARITY_EN
    output logic [DATA_WIDTH/8-1:0]   ram_perra,
    output logic [DATA_WIDTH/8-1:0]   ram_perrb,
`endif
    output logic                      ram_coll,
    output logic [15:0]               ram_coll_cnt
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = MEM_SIZE / NB;
    localparam logic [ADDR_MSB+1:0] DEPTH_W = DEPTH[ADDR_MSB+1:0];

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  a_act, b_act, a_ok, b_ok, same_addr, coll_now;
    logic [NB-1:0]         a_wr, b_wr;
    logic [DATA_WIDTH-1:0] a_word, b_word, a_rd, b_rd;

    // Port A owns any lane both ports write at the same address, so B's
    // write mask is trimmed before it reaches the array.
    always_comb begin
        a_act     = ~ram_cena;
        b_act     = ~ram_cenb;
        a_ok      = {1'b0, ram_addra} < DEPTH_W;
        b_ok      = {1'b0, ram_addrb} < DEPTH_W;
        same_addr = (ram_addra == ram_addrb);
        a_wr      = {NB{a_act & a_ok}} & ~ram_wena;
        b_wr      = {NB{b_act & b_ok}} & ~ram_wenb & ~({NB{same_addr}} & a_wr);
        coll_now  = a_act & b_act & same_addr & ((|(~ram_wena)) | (|(~ram_wenb)));
        a_word    = a_ok ? mem[ram_addra] : '0;
        b_word    = b_ok ? mem[ram_addrb] : '0;
        a_rd      = a_word;
        b_rd      = b_word;
        if (RDW_MODE == 1) begin
            for (int i = 0; i < NB; i++) begin
                if (a_wr[i])
                    a_rd[i*8 +: 8] = ram_dina[i*8 +: 8];
                else if (same_addr && b_wr[i])
                    a_rd[i*8 +: 8] = ram_dinb[i*8 +: 8];
                if (b_wr[i])
                    b_rd[i*8 +: 8] = ram_dinb[i*8 +: 8];
                else if (same_addr && a_wr[i])
                    b_rd[i*8 +: 8] = ram_dina[i*8 +: 8];
            end
        end
    end

`ifdef RAM_DP_SYNC_PARITY_EN
    logic [NB-1:0]                 mem_par [0:DEPTH-1];
    logic [NB-1:0]                 a_perr, b_perr;
    logic                          flip_tog, flip_seen;
    logic [ADDR_MSB:0]             flip_addr;
    logic [$clog2(DATA_WIDTH)-1:0] flip_pos;

    // Bench-only hook: the request is picked up on the next clock edge.
    task automatic flip_bit(input logic [ADDR_MSB:0] addr,
                            input logic [$clog2(DATA_WIDTH)-1:0] bitpos);
        flip_addr = addr;
        flip_pos  = bitpos;
        flip_tog  = ~flip_tog;
    endtask

    always_comb begin
        a_perr = '0;
        b_perr = '0;
        for (int i = 0; i < NB; i++) begin
            a_perr[i] = a_ok & ((^a_word[i*8 +: 8]) ^ (a_ok ? mem_par[ram_addra][i] : 1'b0));
            b_perr[i] = b_ok & ((^b_word[i*8 +: 8]) ^ (b_ok ? mem_par[ram_addrb][i] : 1'b0));
        end
    end
`endif

    // Array is never reset; reset held across an edge suppresses that edge's write.
    always_ff @(posedge mclk) begin
        if (!puc_rst) begin
            for (int i = 0; i < NB; i++) begin
                if (a_wr[i]) begin
                    mem[ram_addra][i*8 +: 8] <= ram_dina[i*8 +: 8];
`ifdef RAM_DP_SYNC_PARITY_EN
                    mem_par[ram_addra][i]    <= ^ram_dina[i*8 +: 8];
`endif
                end
                if (b_wr[i]) begin
                    mem[ram_addrb][i*8 +: 8] <= ram_dinb[i*8 +: 8];
`ifdef RAM_DP_SYNC_PARITY_EN
                    mem_par[ram_addrb][i]    <= ^ram_dinb[i*8 +: 8];
`endif
                end
            end
`ifdef RAM_DP_SYNC_PARITY_EN
            flip_seen <= flip_tog;
            if (flip_seen != flip_tog)
                mem[flip_addr][flip_pos] <= ~mem[flip_addr][flip_pos];
`endif
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ram_douta    <= '0;
            ram_doutb    <= '0;
            ram_coll     <= 1'b0;
            ram_coll_cnt <= 16'd0;
`ifdef RAM_DP_SYNC_PARITY_EN
            ram_perra    <= '0;
            ram_perrb    <= '0;
`endif
        end else begin
            if (a_act) begin
                ram_douta <= a_rd;
`ifdef RAM_DP_SYNC_PARITY_EN
                ram_perra <= a_perr;
`endif
            end
            if (b_act) begin
                ram_doutb <= b_rd;
`ifdef RAM_DP_SYNC_PARITY_EN
                ram_perrb <= b_perr;
`endif
            end
            ram_coll <= coll_now;
            if (coll_now && (ram_coll_cnt != 16'hFFFF))
                ram_coll_cnt <= ram_coll_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ram_dp_sync.sv
// Directed bench for ram_dp_sync: vector table plus reset, saturation and parity sequences.
// MEM_SIZE is reduced so that address DEPTH fits in the 7-bit address bus.
module tb_ram_dp_sync;

    localparam int RDW = 0;

    logic        mclk, puc_rst;
    logic [6:0]  ram_addra, ram_addrb;
    logic        ram_cena, ram_cenb;
    logic [1:0]  ram_wena, ram_wenb;
    logic [15:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
    logic        ram_coll;
    logic [15:0] ram_coll_cnt;
`ifdef RAM_DP_SYNC_PARITY_EN
    logic [1:0]  ram_perra, ram_perrb;
`endif

    int checks = 0;
    int errors = 0;

    ram_dp_sync #(.ADDR_MSB(6), .MEM_SIZE(192), .DATA_WIDTH(16), .RDW_MODE(RDW)) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .ram_addra(ram_addra), .ram_cena(ram_cena), .ram_wena(ram_wena),
        .ram_dina(ram_dina), .ram_douta(ram_douta),
        .ram_addrb(ram_addrb), .ram_cenb(ram_cenb), .ram_wenb(ram_wenb),
        .ram_dinb(ram_dinb), .ram_doutb(ram_doutb),
`ifdef RAM_DP_SYNC_PARITY_EN
        .ram_perra(ram_perra), .ram_perrb(ram_perrb),
`endif
        .ram_coll(ram_coll), .ram_coll_cnt(ram_coll_cnt)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    typedef struct {
        logic        cena;
        logic [1:0]  wena;
        logic [6:0]  addra;
        logic [15:0] dina;
        logic        cenb;
        logic [1:0]  wenb;
        logic [6:0]  addrb;
        logic [15:0] dinb;
        logic        chka;
        logic [15:0] expa;
        logic        chkb;
        logic [15:0] expb;
        logic        expcoll;
        logic [15:0] expcnt;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic applyStimulus(input logic ca, input logic [1:0] wa, input logic [6:0] aa,
                                 input logic [15:0] da, input logic cb, input logic [1:0] wb,
                                 input logic [6:0] ab, input logic [15:0] db);
        ram_cena = ca; ram_wena = wa; ram_addra = aa; ram_dina = da;
        ram_cenb = cb; ram_wenb = wb; ram_addrb = ab; ram_dinb = db;
        @(posedge mclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'b00, 7'd5,  16'h1234, 1'b0, 2'b00, 7'd9,  16'h1111,
                     1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 2'b10, 7'd5,  16'hABCD, 1'b1, 2'b11, 7'd0,  16'h0,
                     1'b1, (RDW != 0) ? 16'h12CD : 16'h1234, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 2'b11, 7'd0,  16'h0,    1'b0, 2'b11, 7'd5,  16'h0,
                     1'b1, (RDW != 0) ? 16'h12CD : 16'h1234, 1'b1, 16'h12CD, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 2'b00, 7'd7,  16'hAAAA, 1'b0, 2'b00, 7'd7,  16'h5555,
                     1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'd1};
        vecs[4]  = '{1'b0, 2'b11, 7'd7,  16'h0,    1'b0, 2'b11, 7'd7,  16'h0,
                     1'b1, 16'hAAAA, 1'b1, 16'hAAAA, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 2'b00, 7'd9,  16'h2222, 1'b0, 2'b11, 7'd9,  16'h0,
                     1'b1, (RDW != 0) ? 16'h2222 : 16'h1111,
                     1'b1, (RDW != 0) ? 16'h2222 : 16'h1111, 1'b1, 16'd2};
        vecs[6]  = '{1'b0, 2'b11, 7'd9,  16'h0,    1'b0, 2'b00, 7'd0,  16'h0F0F,
                     1'b1, 16'h2222, 1'b0, 16'h0, 1'b0, 16'd2};
        vecs[7]  = '{1'b0, 2'b10, 7'd7,  16'h00BB, 1'b0, 2'b01, 7'd7,  16'hCC00,
                     1'b1, (RDW != 0) ? 16'hCCBB : 16'hAAAA,
                     1'b1, (RDW != 0) ? 16'hCCBB : 16'hAAAA, 1'b1, 16'd3};
        vecs[8]  = '{1'b0, 2'b11, 7'd7,  16'h0,    1'b1, 2'b11, 7'd0,  16'h0,
                     1'b1, 16'hCCBB, 1'b0, 16'h0, 1'b0, 16'd3};
        vecs[9]  = '{1'b0, 2'b00, 7'd96, 16'hDEAD, 1'b1, 2'b11, 7'd0,  16'h0,
                     1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 16'd3};
        vecs[10] = '{1'b0, 2'b11, 7'd96, 16'h0,    1'b0, 2'b11, 7'd0,  16'h0,
                     1'b1, 16'h0, 1'b1, 16'h0F0F, 1'b0, 16'd3};
        vecs[11] = '{1'b1, 2'b11, 7'd0,  16'h0,    1'b1, 2'b11, 7'd0,  16'h0,
                     1'b1, 16'h0, 1'b1, 16'h0F0F, 1'b0, 16'd3};
        vecs[12] = '{1'b0, 2'b00, 7'd11, 16'h3333, 1'b0, 2'b11, 7'd11, 16'h0,
                     1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'd4};
        vecs[13] = '{1'b0, 2'b00, 7'd11, 16'h4444, 1'b0, 2'b11, 7'd11, 16'h0,
                     1'b1, (RDW != 0) ? 16'h4444 : 16'h3333,
                     1'b1, (RDW != 0) ? 16'h4444 : 16'h3333, 1'b1, 16'd5};
        vecs[14] = '{1'b1, 2'b11, 7'd0,  16'h0,    1'b1, 2'b11, 7'd0,  16'h0,
                     1'b1, (RDW != 0) ? 16'h4444 : 16'h3333,
                     1'b1, (RDW != 0) ? 16'h4444 : 16'h3333, 1'b0, 16'd5};

        puc_rst = 1'b1;
        ram_cena = 1'b1; ram_wena = 2'b11; ram_addra = '0; ram_dina = '0;
        ram_cenb = 1'b1; ram_wenb = 2'b11; ram_addrb = '0; ram_dinb = '0;
        repeat (2) @(posedge mclk);
        #1;
        checkOutput("reset douta", ram_douta, 16'h0);
        checkOutput("reset doutb", ram_doutb, 16'h0);
        checkOutput("reset coll", {15'b0, ram_coll}, 16'h0);
        checkOutput("reset cnt", ram_coll_cnt, 16'h0);
        puc_rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].cena, vecs[i].wena, vecs[i].addra, vecs[i].dina,
                          vecs[i].cenb, vecs[i].wenb, vecs[i].addrb, vecs[i].dinb);
            if (vecs[i].chka)
                checkOutput($sformatf("vec%0d douta", i), ram_douta, vecs[i].expa);
            if (vecs[i].chkb)
                checkOutput($sformatf("vec%0d doutb", i), ram_doutb, vecs[i].expb);
            checkOutput($sformatf("vec%0d coll", i), {15'b0, ram_coll}, {15'b0, vecs[i].expcoll});
            checkOutput($sformatf("vec%0d cnt", i), ram_coll_cnt, vecs[i].expcnt);
        end

        // Reset arrives mid-cycle while port A is writing 0xBEEF to addr 3.
        applyStimulus(1'b0, 2'b00, 7'd3, 16'h5A5A, 1'b1, 2'b11, 7'd0, 16'h0);
        ram_cena = 1'b0; ram_wena = 2'b00; ram_addra = 7'd3; ram_dina = 16'hBEEF;
        ram_cenb = 1'b0; ram_wenb = 2'b11; ram_addrb = 7'd3;
        #2 puc_rst = 1'b1;
        @(posedge mclk);
        #1;
        checkOutput("midrst douta", ram_douta, 16'h0);
        checkOutput("midrst doutb", ram_doutb, 16'h0);
        checkOutput("midrst coll", {15'b0, ram_coll}, 16'h0);
        checkOutput("midrst cnt", ram_coll_cnt, 16'h0);
        ram_cena = 1'b1; ram_wena = 2'b11; ram_cenb = 1'b1;
        puc_rst = 1'b0;
        applyStimulus(1'b0, 2'b11, 7'd3, 16'h0, 1'b0, 2'b11, 7'd3, 16'h0);
        checkOutput("aborted write A", ram_douta, 16'h5A5A);
        checkOutput("aborted write B", ram_doutb, 16'h5A5A);
        checkOutput("readread coll", {15'b0, ram_coll}, 16'h0);

        // Continuous collisions drive the counter into saturation.
        ram_cena = 1'b0; ram_wena = 2'b00; ram_addra = 7'd12; ram_dina = 16'h0001;
        ram_cenb = 1'b0; ram_wenb = 2'b11; ram_addrb = 7'd12;
        repeat (65534) @(posedge mclk);
        #1;
        checkOutput("sat cnt-1", ram_coll_cnt, 16'hFFFE);
        repeat (1) @(posedge mclk);
        #1;
        checkOutput("sat cnt", ram_coll_cnt, 16'hFFFF);
        checkOutput("b2b coll", {15'b0, ram_coll}, 16'h1);
        repeat (6) @(posedge mclk);
        #1;
        checkOutput("sat nowrap", ram_coll_cnt, 16'hFFFF);
        applyStimulus(1'b1, 2'b11, 7'd0, 16'h0, 1'b1, 2'b11, 7'd0, 16'h0);
        checkOutput("coll drop", {15'b0, ram_coll}, 16'h0);
        checkOutput("sat hold", ram_coll_cnt, 16'hFFFF);

`ifdef RAM_DP_SYNC_PARITY_EN
        applyStimulus(1'b0, 2'b00, 7'd2, 16'h00FF, 1'b1, 2'b11, 7'd0, 16'h0);
        applyStimulus(1'b0, 2'b00, 7'd4, 16'h1234, 1'b1, 2'b11, 7'd0, 16'h0);
        dut.flip_bit(7'd2, 4'd0);
        applyStimulus(1'b1, 2'b11, 7'd0, 16'h0, 1'b1, 2'b11, 7'd0, 16'h0);
        applyStimulus(1'b0, 2'b11, 7'd2, 16'h0, 1'b1, 2'b11, 7'd0, 16'h0);
        checkOutput("par data", ram_douta, 16'h00FE);
        checkOutput("par perra", {14'b0, ram_perra}, 16'h0001);
        applyStimulus(1'b0, 2'b11, 7'd4, 16'h0, 1'b1, 2'b11, 7'd0, 16'h0);
        checkOutput("par clean", {14'b0, ram_perra}, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dp_sync.md
Name: ram_dp_sync

Overview:
- Parametrised single-clock true dual-port RAM for the MSP430 bench and FPGA targets; it generalises the existing two-port data-memory model.
- Adds configurable data width with per-byte write enables and a registered read port on each side.
- Resolves same-address collisions deterministically and counts them with a saturating counter.
- Sits behind the memory backbone / DMA path, where CPU and DMA access DMEM concurrently.

Parameters:
ADDR_MSB, 6, MSB of word address; address width = ADDR_MSB+1.
MEM_SIZE, 256, memory size in bytes.
DATA_WIDTH, 16, word width in bits; must be a multiple of 8 (8, 16, 32).
RDW_MODE, 0, read-during-write result: 0 = old data (read-first), 1 = new data (write-first).

Ports:
mclk  input  1  clock, all logic rising-edge.
puc_rst  input  1  asynchronous active-high reset.
ram_addra  input  ADDR_MSB+1  port A word address.
ram_cena  input  1  port A chip enable, low active.
ram_wena  input  DATA_WIDTH/8  port A byte write enables, low active.
ram_dina  input  DATA_WIDTH  port A write data.
ram_douta  output  DATA_WIDTH  port A registered read data.
ram_addrb  input  ADDR_MSB+1  port B word address.
ram_cenb  input  1  port B chip enable, low active.
ram_wenb  input  DATA_WIDTH/8  port B byte write enables, low active.
ram_dinb  input  DATA_WIDTH  port B write data.
ram_doutb  output  DATA_WIDTH  port B registered read data.
ram_coll  output  1  one-cycle pulse: collision occurred in the previous access cycle.
ram_coll_cnt  output  16  saturating collision count.

Behaviour:
- Clocking and reset: one clock, mclk. Reset is asynchronous and active-high, on puc_rst.
- Reset values: ram_douta = 0, ram_doutb = 0, ram_coll = 0, ram_coll_cnt = 0. The array contents are NOT cleared. Reset mid-access aborts that cycle's write and clears the output registers.
- Depth: DEPTH = MEM_SIZE/(DATA_WIDTH/8) words.
- Out-of-range addresses: address >= DEPTH drops the write and returns 0 on the read.
- Access: a port is active when cen = 0. Byte lane i of the addressed word is written on the rising edge when cen = 0 and wen[i] = 0.
- Read latency: 1 cycle. dout updates on every active cycle, including write cycles, and holds its value while cen = 1.
- Same-port read-during-write: non-written lanes always return the stored data. Written lanes return old data if RDW_MODE = 0, or the new dina lane if RDW_MODE = 1.
- Collision condition: both ports active, ram_addra == ram_addrb, and at least one port writing at least one lane.
- Write-write, same lane: port A wins; port B's lane is discarded. Disjoint lanes are both written.
- Cross-port read-during-write: the reading port sees old data (RDW_MODE = 0) or the winning written data (RDW_MODE = 1), per lane.
- Read-read at the same address is not a collision.
- Collision reporting: ram_coll is registered and asserted the cycle after the collision, for exactly one cycle per colliding cycle. ram_coll_cnt increments on the same edge and saturates at 0xFFFF with no wrap. Back-to-back collisions pulse ram_coll continuously.

Optional Feature:
- Macro: RAM_DP_SYNC_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte lane and written with that lane.
  - Each read checks parity on the stored data and drives outputs ram_perra / ram_perrb (DATA_WIDTH/8 bits each, registered with dout, reset 0), one bit per failing lane.
  - A bench-only task flip_bit(addr, bit) corrupts the array for test.
- When undefined: no parity storage, no ram_perr ports, and the area is identical to the base block.

Test Plan:
- Reset/hold: assert puc_rst mid-write of 0xBEEF to addr 3 -> douta = doutb = 0, ram_coll_cnt = 0. After release, read addr 3 -> the pre-reset value (write aborted).
- Byte enables: write 0x1234 to addr 5 (wena = 00), then 0xABCD with wena = 10 -> a read on port B one cycle later returns 0x12CD.
- Write-write collision: A writes 0xAAAA and B writes 0x5555, same addr 7, both wen = 00 -> addr 7 reads 0xAAAA, ram_coll = 1 for one cycle, ram_coll_cnt = 1.
- Cross-port RDW: addr 9 holds 0x1111; A writes 0x2222 while B reads addr 9 -> doutb = 0x1111 (RDW_MODE = 0) or 0x2222 (RDW_MODE = 1), and the collision is counted.
- Saturation/range: 70000 consecutive collision cycles -> ram_coll_cnt = 0xFFFF. Write to addr DEPTH -> no array change, read of that addr returns 0.
- Parity (macro on): write 0x00FF to addr 2, flip_bit(2, 0), read -> perr = 01 with data 0x00FE. Read addr 4 (clean) -> perr = 00.
